// File: rtl/oam_dma_pkg.sv
`default_nettype none
// ============================================================================
// oam_dma_pkg : shared types and constants for the CPU bus front-end / OAM DMA
// Revision: 1.0
// ============================================================================
package oam_dma_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTING = 2'd1,
      ACTIVE   = 2'd2
   } dma_state_e;

   localparam int unsigned DMA_LEN_DEFAULT    = 160;
   localparam logic [7:0]  DMA_REG_LO_DEFAULT = 8'h46;
   localparam logic [7:0]  HIGH_PAGE          = 8'hFF;

   // Source pages E0-FF alias the C0-DF work RAM.
   function automatic logic [7:0] eff_src(input logic [7:0] src);
      return (src >= 8'hE0) ? (src - 8'h20) : src;
   endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
// oam_dma_if : CPU-side, main-bus, high-page and OAM signal bundle
// Revision: 1.0
// ============================================================================
interface oam_dma_if;
   logic [15:0] cpu_addr;
   logic        cpu_enable;
   logic        cpu_write;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] bus_addr;
   logic        bus_enable;
   logic        bus_write;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic [7:0]  hi_addr;
   logic        hi_enable;
   logic        hi_write;
   logic [7:0]  hi_wdata;
   logic [7:0]  hi_rdata;
   logic [7:0]  oam_addr;
   logic        oam_write;
   logic [7:0]  oam_wdata;
   logic        dma_active;

   modport master (
      input  cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
      output cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
             hi_addr, hi_enable, hi_write, hi_wdata,
             oam_addr, oam_write, oam_wdata, dma_active
   );

   modport slave (
      output cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
      input  cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
             hi_addr, hi_enable, hi_write, hi_wdata,
             oam_addr, oam_write, oam_wdata, dma_active
   );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// oam_dma : CPU bus front-end with high-page routing and OAM DMA engine
// Revision: 1.0
// ============================================================================
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int unsigned DMA_LEN    = DMA_LEN_DEFAULT,
   parameter logic [7:0]  DMA_REG_LO = DMA_REG_LO_DEFAULT
) (
   input  wire logic clk,
   input  wire logic reset,
   oam_dma_if.master bus_if
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_e state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [7:0] src_q, src_d;
   logic [7:0] idx_q, idx_d;
   logic       owns_q, owns_d;

   logic w_hi_page;
   logic w_dma_reg;
   logic w_m_end;
   logic w_dma_wr;

   assign w_hi_page = (bus_if.cpu_addr[15:8] == HIGH_PAGE);
   assign w_dma_reg = w_hi_page && (bus_if.cpu_addr[7:0] == DMA_REG_LO);
   assign w_m_end   = (phase_q == 2'd3);
   assign w_dma_wr  = bus_if.cpu_enable && bus_if.cpu_write && w_dma_reg && w_m_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         phase_q <= 2'd0;
         src_q   <= 8'h00;
         idx_q   <= 8'h00;
         owns_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         src_q   <= src_d;
         idx_q   <= idx_d;
         owns_q  <= owns_d;
      end
   end

   // A register write always restarts; owns is left alone so a restart keeps the CPU locked.
   always_comb begin
      phase_d = phase_q + 2'd1;
      state_d = state_q;
      src_d   = src_q;
      idx_d   = idx_q;
      owns_d  = owns_q;
      if (w_m_end) begin
         if (w_dma_wr) begin
            state_d = STARTING;
            src_d   = bus_if.cpu_wdata;
            idx_d   = 8'h00;
         end else begin
            case (state_q)
               STARTING: begin
                  state_d = ACTIVE;
                  owns_d  = 1'b1;
               end
               ACTIVE: begin
                  idx_d = idx_q + 8'h01;
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     owns_d  = 1'b0;
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_comb begin
      bus_if.hi_addr   = bus_if.cpu_addr[7:0];
      bus_if.hi_enable = bus_if.cpu_enable && w_hi_page && !w_dma_reg;
      bus_if.hi_write  = bus_if.hi_enable && bus_if.cpu_write;
      bus_if.hi_wdata  = bus_if.cpu_wdata;

      if (owns_q) begin
         bus_if.bus_addr   = {eff_src(src_q), idx_q};
         bus_if.bus_enable = (state_q == ACTIVE);
         bus_if.bus_write  = 1'b0;
         bus_if.bus_wdata  = 8'h00;
      end else begin
         bus_if.bus_addr   = bus_if.cpu_addr;
         bus_if.bus_enable = bus_if.cpu_enable && !w_hi_page;
         bus_if.bus_write  = bus_if.bus_enable && bus_if.cpu_write;
         bus_if.bus_wdata  = bus_if.cpu_wdata;
      end

      // The byte of an M-cycle aborted by a restart is discarded.
      bus_if.oam_addr   = idx_q;
      bus_if.oam_wdata  = bus_if.bus_rdata;
      bus_if.oam_write  = (state_q == ACTIVE) && w_m_end && !w_dma_wr;
      bus_if.dma_active = owns_q;

      bus_if.cpu_rdata = 8'hFF;
      if (bus_if.cpu_enable) begin
         if (w_dma_reg) begin
            bus_if.cpu_rdata = src_q;
         end else if (w_hi_page) begin
            bus_if.cpu_rdata = bus_if.hi_rdata;
         end else if (!owns_q) begin
            bus_if.cpu_rdata = bus_if.bus_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// tb_oam_dma : directed self-checking bench for oam_dma
// Revision: 1.0
// ============================================================================
module tb_oam_dma;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   oam_dma_if bif();

   oam_dma dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (bif.master)
   );

   always #5 clk = ~clk;

   int          ncmp  = 0;
   int          nfail = 0;
   logic [7:0]  oam    [256];
   logic [7:0]  hi_mem [256];
   int unsigned cyc        = 0;
   int unsigned oam_wr_cnt = 0;
   int unsigned bad_phase  = 0;
   int unsigned drop_cnt   = 0;
   logic [1:0]  tb_ph      = 2'd0;
   logic        watch      = 1'b0;

   // Main memory content is a fixed function of the address.
   function automatic logic [7:0] memval(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign bif.bus_rdata = memval(bif.bus_addr);
   assign bif.hi_rdata  = hi_mem[bif.hi_addr];

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      tb_ph <= reset ? 2'd0 : tb_ph + 2'd1;
      if (bif.oam_write) begin
         oam[bif.oam_addr] <= bif.oam_wdata;
         oam_wr_cnt        <= oam_wr_cnt + 1;
         if (tb_ph != 2'd3) bad_phase <= bad_phase + 1;
      end
      if (bif.hi_enable && bif.hi_write && tb_ph == 2'd3)
         hi_mem[bif.hi_addr] <= bif.hi_wdata;
   end

   always @(negedge clk) if (watch && !bif.dma_active) drop_cnt <= drop_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
      bif.cpu_enable = en;
      bif.cpu_write  = wr;
      bif.cpu_addr   = a;
      bif.cpu_wdata  = d;
   endtask

   task automatic finish_m();
      repeat (4) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic wait_done(input int unsigned start, output int unsigned took);
      while (bif.dma_active && (cyc - start) < 2000) begin
         @(posedge clk);
         #1;
      end
      took = cyc - start;
   endtask

   task automatic chk_oam(input string tag, input logic [7:0] page);
      int errs = 0;
      for (int k = 0; k < 160; k++)
         if (oam[k] !== memval({page, 8'(k)})) errs++;
      chk(tag, errs, 0);
   endtask

   initial begin
      int unsigned start;
      int unsigned took;
      int unsigned wr0;

      drive(1'b0, 1'b0, 16'h0000, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dma_active", bif.dma_active, 0);
      chk("rst_oam_write",  bif.oam_write, 0);
      chk("rst_bus_enable", bif.bus_enable, 0);
      chk("rst_hi_enable",  bif.hi_enable, 0);
      chk("rst_cpu_rdata",  bif.cpu_rdata, 8'hFF);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Plain pass-through read
      drive(1'b1, 1'b0, 16'hC123, 8'h00);
      #1;
      chk("pt_bus_addr",   bif.bus_addr, 16'hC123);
      chk("pt_bus_enable", bif.bus_enable, 1);
      chk("pt_bus_write",  bif.bus_write, 0);
      chk("pt_cpu_rdata",  bif.cpu_rdata, memval(16'hC123));
      chk("pt_hi_enable",  bif.hi_enable, 0);
      finish_m();

      // DMA from C0 page, with CPU traffic while locked
      start = cyc;
      drive(1'b1, 1'b1, 16'hFF46, 8'hC0);
      #1;
      chk("reg_not_fwd_hi",  bif.hi_enable, 0);
      chk("reg_not_fwd_bus", bif.bus_enable, 0);
      finish_m();
      wr0 = oam_wr_cnt;
      #1;
      chk("start_dma_active", bif.dma_active, 0);
      finish_m();
      chk("start_no_oam",  oam_wr_cnt - wr0, 0);
      chk("act_dma_active", bif.dma_active, 1);

      drive(1'b1, 1'b0, 16'h0150, 8'h00);
      #1;
      chk("lock_rd_ff",     bif.cpu_rdata, 8'hFF);
      chk("dma_addr0",      bif.bus_addr, 16'hC000);
      chk("dma_bus_enable", bif.bus_enable, 1);
      finish_m();
      drive(1'b1, 1'b1, 16'hC000, 8'hAA);
      #1;
      chk("lock_wr_drop", bif.bus_write, 0);
      chk("dma_addr1",    bif.bus_addr, 16'hC001);
      finish_m();
      drive(1'b1, 1'b1, 16'hFF80, 8'h3C);
      #1;
      chk("hi_en_during_dma", bif.hi_enable, 1);
      chk("hi_addr",          bif.hi_addr, 8'h80);
      chk("hi_write",         bif.hi_write, 1);
      finish_m();
      drive(1'b1, 1'b0, 16'hFF80, 8'h00);
      #1;
      chk("hi_roundtrip", bif.cpu_rdata, 8'h3C);
      finish_m();
      drive(1'b1, 1'b0, 16'hFF46, 8'h00);
      #1;
      chk("reg_rd_c0", bif.cpu_rdata, 8'hC0);
      finish_m();
      wait_done(start, took);
      chk("c0_total_clk", took, 648);
      chk("c0_oam_count", oam_wr_cnt - wr0, 160);
      chk_oam("c0_oam_data", 8'hC0);

      // Mirror page E1 -> C1
      start = cyc;
      wr0   = oam_wr_cnt;
      drive(1'b1, 1'b1, 16'hFF46, 8'hE1);
      finish_m();
      finish_m();
      drive(1'b1, 1'b0, 16'hFF46, 8'h00);
      #1;
      chk("e1_addr0",  bif.bus_addr, 16'hC100);
      chk("reg_rd_e1", bif.cpu_rdata, 8'hE1);
      finish_m();
      wait_done(start, took);
      chk("e1_total_clk", took, 648);
      chk("e1_oam_count", oam_wr_cnt - wr0, 160);
      chk_oam("e1_oam_data", 8'hC1);

      // Restart at idx 0x50
      drive(1'b1, 1'b1, 16'hFF46, 8'h80);
      finish_m();
      finish_m();
      wr0   = oam_wr_cnt;
      watch = 1'b1;
      repeat (8'h50) finish_m();
      drive(1'b1, 1'b1, 16'hFF46, 8'hD0);
      #1;
      chk("rs_pre_addr", bif.bus_addr, 16'h8050);
      finish_m();
      chk("rs_aborted_byte", oam_wr_cnt - wr0, 32'h50);
      start = cyc;
      #1;
      chk("rs_start_dma_active", bif.dma_active, 1);
      chk("rs_start_bus_enable", bif.bus_enable, 0);
      finish_m();
      wait_done(start, took);
      watch = 1'b0;
      chk("rs_total_clk",  took, 644);
      chk("rs_oam_count",  oam_wr_cnt - wr0, 32'h50 + 160);
      chk("rs_no_unlock",  drop_cnt, 0);
      chk_oam("rs_oam_data", 8'hD0);

      // Reset mid-transfer at idx 0x20
      drive(1'b1, 1'b1, 16'hFF46, 8'hC0);
      finish_m();
      finish_m();
      repeat (8'h20) finish_m();
      wr0   = oam_wr_cnt;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_dma_active", bif.dma_active, 0);
      chk("mr_oam_write",  bif.oam_write, 0);
      chk("mr_bus_enable", bif.bus_enable, 0);
      reset = 1'b0;
      repeat (700) @(posedge clk);
      #1;
      chk("mr_no_more_oam", oam_wr_cnt - wr0, 0);
      chk("mr_oam_1f",      oam[8'h1F], memval(16'hC01F));
      chk("mr_oam_20",      oam[8'h20], memval(16'hD020));
      drive(1'b1, 1'b0, 16'hFF46, 8'h00);
      #1;
      chk("mr_src_cleared", bif.cpu_rdata, 8'h00);
      finish_m();

      chk("oam_phase3_only", bad_phase, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
